// File: rtl/vadd_const_engine.sv
// vadd_const_engine: element-wise "vector + constant" compute stage.
// Reads 64-bit elements from inp_baddr, adds a zero-extended constant and
// writes each sum to out_baddr, one memory request in flight at a time.
// Reports completion with a one-cycle finish pulse carrying the busy-cycle count.
module vadd_const_engine #(
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64,
  parameter int HOST_DATA_BITS = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  output logic                      finish,
  output logic                      event_counter_valid,
  output logic [HOST_DATA_BITS-1:0] event_counter_value,
  input  logic [HOST_DATA_BITS-1:0] constant,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [MEM_ADDR_BITS-1:0]  inp_baddr,
  input  logic [MEM_ADDR_BITS-1:0]  out_baddr,
  output logic                      mem_req_valid,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  output logic                      mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  input  logic                      mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_rd_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [HOST_DATA_BITS-1:0] const_q, const_d;
  logic [HOST_DATA_BITS-1:0] len_q,   len_d;
  logic [MEM_ADDR_BITS-1:0]  inp_q,   inp_d;
  logic [MEM_ADDR_BITS-1:0]  out_q,   out_d;
  logic [HOST_DATA_BITS-1:0] idx_q,   idx_d;
  logic [HOST_DATA_BITS-1:0] count_q, count_d;
  logic [MEM_DATA_BITS-1:0]  sum_q,   sum_d;

  // Byte offset of the current element (8 bytes per element); wraps at the
  // address width like the rest of the address arithmetic.
  logic [MEM_ADDR_BITS-1:0]  elem_off;
  assign elem_off = MEM_ADDR_BITS'(idx_q) << 3;

  // True while the engine is working on an element; these cycles are counted.
  logic busy;
  assign busy = (state_q == S_RD_REQ) || (state_q == S_RD_DATA) ||
                (state_q == S_WR_REQ) || (state_q == S_WR_DATA);

  // State and datapath registers; reset aborts any run without a finish pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      const_q <= '0;
      len_q   <= '0;
      inp_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      const_q <= const_d;
      len_q   <= len_d;
      inp_q   <= inp_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state and datapath update: latch the job on launch, then walk the
  // vector as read-request / read-data / write-request / write-data per element.
  always_comb begin
    state_d = state_q;
    const_d = const_q;
    len_d   = len_q;
    inp_d   = inp_q;
    out_d   = out_q;
    idx_d   = idx_q;
    count_d = busy ? count_q + 1'b1 : count_q;
    sum_d   = sum_q;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          const_d = constant;
          len_d   = length;
          inp_d   = inp_baddr;
          out_d   = out_baddr;
          idx_d   = '0;
          count_d = '0;
          state_d = (length == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        // Wait indefinitely for the read data; the carry out of the add is dropped.
        if (mem_rd_valid) begin
          sum_d   = mem_rd_bits + MEM_DATA_BITS'(const_q);
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (idx_q == len_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so no input reaches an output
  // combinationally; every output is zero outside the state that drives it.
  always_comb begin
    finish              = 1'b0;
    event_counter_valid = 1'b0;
    event_counter_value = '0;
    mem_req_valid       = 1'b0;
    mem_req_opcode      = 1'b0;
    mem_req_len         = '0;
    mem_req_addr        = '0;
    mem_wr_valid        = 1'b0;
    mem_wr_bits         = '0;
    mem_rd_ready        = 1'b0;

    case (state_q)
      S_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = inp_q + elem_off;
      end
      S_RD_DATA: begin
        mem_rd_ready = 1'b1;
      end
      S_WR_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = 1'b1;
        mem_req_addr   = out_q + elem_off;
      end
      S_WR_DATA: begin
        mem_wr_valid = 1'b1;
        mem_wr_bits  = sum_q;
      end
      S_DONE: begin
        finish              = 1'b1;
        event_counter_valid = 1'b1;
        event_counter_value = count_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_vadd_const_engine.sv
// Bench for vadd_const_engine: a memory responder with programmable read
// latency, plus queues of expected read addresses, writes and cycle counts.
module tb_vadd_const_engine;
  localparam int L = 8;
  localparam int A = 64;
  localparam int D = 64;
  localparam int H = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         launch = 1'b0;
  logic         finish;
  logic         event_counter_valid;
  logic [H-1:0] event_counter_value;
  logic [H-1:0] constant = '0;
  logic [H-1:0] length = '0;
  logic [A-1:0] inp_baddr = '0;
  logic [A-1:0] out_baddr = '0;
  logic         mem_req_valid;
  logic         mem_req_opcode;
  logic [L-1:0] mem_req_len;
  logic [A-1:0] mem_req_addr;
  logic         mem_wr_valid;
  logic [D-1:0] mem_wr_bits;
  logic         mem_rd_valid = 1'b0;
  logic [D-1:0] mem_rd_bits = '0;
  logic         mem_rd_ready;

  always #5 clock = ~clock;

  vadd_const_engine #(
    .MEM_LEN_BITS(L), .MEM_ADDR_BITS(A), .MEM_DATA_BITS(D), .HOST_DATA_BITS(H)
  ) dut (
    .clock(clock), .reset(reset), .launch(launch),
    .finish(finish), .event_counter_valid(event_counter_valid),
    .event_counter_value(event_counter_value),
    .constant(constant), .length(length),
    .inp_baddr(inp_baddr), .out_baddr(out_baddr),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
    .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
    .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits),
    .mem_rd_ready(mem_rd_ready)
  );

  logic [173:0] all_outs;
  assign all_outs = {finish, event_counter_valid, event_counter_value,
                     mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
                     mem_wr_valid, mem_wr_bits, mem_rd_ready};

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [63:0] rd_q[$];
  logic [31:0] cnt_q[$];
  logic [63:0] mem [logic [63:0]];

  int n_checks = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int rd_wait = 0;
  int rd_delay = 0;
  bit spurious_en = 1'b0;
  bit pend_valid = 1'b0;
  logic [63:0] pend_data = '0;
  logic [63:0] rd_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder and scoreboard consumer, sampling away from the active edge.
  always @(negedge clock) begin
    wr_exp_t     e;
    logic [63:0] a;
    mem_rd_valid = 1'b0;
    mem_rd_bits  = '0;
    if (reset) begin
      rd_wait    = 0;
      pend_valid = 1'b0;
    end else begin
      if (rd_wait > 0) begin
        check_eq("rd_ready_wait", 64'(mem_rd_ready), 64'(1));
        rd_wait--;
        if (rd_wait == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_bits  = rd_data;
        end
      end
      if (mem_req_valid) begin
        check_eq("req_len", 64'(mem_req_len), 64'(0));
        check_eq("rd_ready_in_req", 64'(mem_rd_ready), 64'(0));
        if (!mem_req_opcode) begin
          if (rd_q.size() == 0) begin
            check_eq("unexp_rd_req", 64'(mem_req_valid), 64'(0));
          end else begin
            a = rd_q.pop_front();
            check_eq("rd_addr", mem_req_addr, a);
          end
          rd_data = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 64'h0;
          rd_wait = rd_delay + 1;
        end else begin
          if (wr_q.size() == 0) begin
            check_eq("unexp_wr_req", 64'(mem_req_valid), 64'(0));
          end else begin
            e = wr_q.pop_front();
            check_eq("wr_addr", mem_req_addr, e.addr);
            pend_data  = e.data;
            pend_valid = 1'b1;
          end
          if (spurious_en) begin
            mem_rd_valid = 1'b1;
            mem_rd_bits  = 64'hDEAD_BEEF_0BAD_F00D;
          end
        end
      end
      if (mem_wr_valid) begin
        wr_seen++;
        if (!pend_valid) begin
          check_eq("unexp_wr_data", 64'(mem_wr_valid), 64'(0));
        end else begin
          check_eq("wr_data", mem_wr_bits, pend_data);
        end
        pend_valid = 1'b0;
      end
      if (finish || event_counter_valid) begin
        check_eq("ecv_with_finish", 64'(event_counter_valid), 64'(finish));
        done_seen++;
        if (cnt_q.size() == 0) begin
          check_eq("unexp_finish", 64'(finish), 64'(0));
        end else begin
          check_eq("event_count", 64'(event_counter_value), 64'(cnt_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Push the expected traffic of one run and program the job registers.
  task automatic setup_run(input logic [31:0] len, input logic [31:0] cst,
                           input logic [63:0] inp, input logic [63:0] outb,
                           input int delay);
    logic [63:0] a;
    logic [63:0] d;
    for (int i = 0; i < int'(len); i++) begin
      a = inp + 64'(i) * 64'd8;
      d = (mem.exists(a) ? mem[a] : 64'h0) + {32'h0, cst};
      rd_q.push_back(a);
      wr_q.push_back('{addr: outb + 64'(i) * 64'd8, data: d});
    end
    cnt_q.push_back(len * (32'd4 + 32'(delay)));
    rd_delay  = delay;
    length    = len;
    constant  = cst;
    inp_baddr = inp;
    out_baddr = outb;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000 && done_seen < target; i++) step();
    check_eq("done_reached", 64'(done_seen), 64'(target));
  endtask

  task automatic run_vec(input logic [31:0] len, input logic [31:0] cst,
                         input logic [63:0] inp, input logic [63:0] outb,
                         input int delay);
    int target;
    setup_run(len, cst, inp, outb, delay);
    target = done_seen + 1;
    launch = 1'b1;
    step();
    launch = 1'b0;
    if (len == 0) begin
      check_eq("zero_len_finish", 64'(finish), 64'(1));
      check_eq("zero_len_no_req", 64'(mem_req_valid), 64'(0));
    end
    wait_done(target);
    step();
  endtask

  initial begin
    int target;
    int base;

    // Reset held with launch=1: outputs must stay zero, then a run starts.
    mem[64'h3000] = 64'd100;
    setup_run(32'd1, 32'd7, 64'h3000, 64'h4000, 0);
    target = done_seen + 1;
    reset  = 1'b1;
    launch = 1'b1;
    repeat (3) begin
      step();
      check_eq("reset_outs_zero", 64'(|all_outs), 64'(0));
    end
    reset = 1'b0;
    step();
    check_eq("post_reset_req", 64'(mem_req_valid), 64'(1));
    check_eq("post_reset_opcode", 64'(mem_req_opcode), 64'(0));
    check_eq("post_reset_addr", mem_req_addr, 64'h3000);
    launch = 1'b0;
    wait_done(target);
    step();

    // Single element.
    mem[64'h1000] = 64'd10;
    run_vec(32'd1, 32'd5, 64'h1000, 64'h2000, 0);

    // Multiple elements with carry into the upper word and a full wrap.
    mem[64'h8000] = 64'h0;
    mem[64'h8008] = 64'h1;
    mem[64'h8010] = 64'h2;
    mem[64'h8018] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_vec(32'd4, 32'hFFFF_FFFF, 64'h8000, 64'h9000, 0);

    // Zero length.
    run_vec(32'd0, 32'd9, 64'h1000, 64'h2000, 0);

    // Read backpressure with a spurious rd_valid during each write request.
    mem[64'hA000] = 64'd1000;
    mem[64'hA008] = 64'd2000;
    spurious_en = 1'b1;
    run_vec(32'd2, 32'd3, 64'hA000, 64'hB000, 3);
    spurious_en = 1'b0;

    // Mid-run reset during the write-data cycle of element 1 of 3.
    mem[64'hC000] = 64'd11;
    mem[64'hC008] = 64'd22;
    mem[64'hC010] = 64'd33;
    setup_run(32'd3, 32'd1, 64'hC000, 64'hD000, 0);
    base = wr_seen;
    launch = 1'b1;
    step();
    launch = 1'b0;
    for (int i = 0; i < 200 && wr_seen < base + 2; i++) step();
    check_eq("midrun_reached_wr1", 64'(wr_seen), 64'(base + 2));
    check_eq("midrun_in_wr_data", 64'(mem_wr_valid), 64'(1));
    reset = 1'b1;
    step();
    check_eq("midrun_reset_outs_zero", 64'(|all_outs), 64'(0));
    rd_q.delete();
    wr_q.delete();
    cnt_q.delete();
    reset = 1'b0;
    repeat (4) begin
      step();
      check_eq("midrun_idle_outs_zero", 64'(|all_outs), 64'(0));
    end

    // Relaunch at the same bases: must restart at element 0.
    run_vec(32'd1, 32'd1, 64'hC000, 64'hD000, 0);

    check_eq("queues_drained", 64'(rd_q.size() + wr_q.size() + cnt_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
